// File: rtl/ir_fx_pkg.sv
// Shared types and sizing helpers for the IR frame sequencer slice.
package ir_fx_pkg;

    localparam int FXP_SIZE    = 32;
    localparam int WINDOW_SIZE = 64;

    typedef logic signed [FXP_SIZE-1:0] sample_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } seq_state_t;

    // The FFT runs on a zero-padded frame twice the window length.
    function automatic int fft_size(input int n);
        return 2 * n;
    endfunction

    localparam int FFT_SIZE = fft_size(WINDOW_SIZE);

endpackage

// File: rtl/ir_frame_sequencer_if.sv
// Bundle of sample-rate, FFT, weight-ROM and overlap-add strobes.
// Optional statistics outputs appear when IR_FRAME_SEQUENCER_STATS_EN is defined.
interface ir_frame_sequencer_if #(
    parameter int FXP_W = 32,
    parameter int N     = 64
);
    import ir_fx_pkg::*;

    localparam int AW = $clog2(2 * N);

    // Every *_valid / *_en line is a one-cycle strobe: a word is transferred on
    // each cycle the strobe is high, and there is no ready/back-pressure path,
    // so the receiver must always accept it.
    logic             i_valid;
    logic [FXP_W-1:0] i_sample;
    logic             o_fft_en;
    logic [FXP_W-1:0] o_fft_sample;
    logic             i_fft_valid;
    logic [AW-1:0]    o_ir_addr;
    logic             i_ifft_valid;
    logic             o_ola_acc;
    logic             o_ola_shift;
    logic             o_frame_done;
    logic             o_busy;
    logic             o_overrun;
    seq_state_t       o_dbg_state;
`ifdef IR_FRAME_SEQUENCER_STATS_EN
    logic [15:0]      o_frames_issued;
    logic [15:0]      o_frames_dropped;
`endif

    modport slave (
        input  i_valid, i_sample, i_fft_valid, i_ifft_valid,
        output o_fft_en, o_fft_sample, o_ir_addr, o_ola_acc, o_ola_shift,
        output o_frame_done, o_busy, o_overrun, o_dbg_state
`ifdef IR_FRAME_SEQUENCER_STATS_EN
        , output o_frames_issued, o_frames_dropped
`endif
    );

    modport master (
        output i_valid, i_sample, i_fft_valid, i_ifft_valid,
        input  o_fft_en, o_fft_sample, o_ir_addr, o_ola_acc, o_ola_shift,
        input  o_frame_done, o_busy, o_overrun, o_dbg_state
`ifdef IR_FRAME_SEQUENCER_STATS_EN
        , input o_frames_issued, o_frames_dropped
`endif
    );

endinterface

// File: rtl/ir_frame_pingpong.sv
// Two-bank frame store: one bank fills while the other is read out.
module ir_frame_pingpong #(
    parameter  int W  = 32,
    parameter  int N  = 64,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic          i_wr_bank,
    input  logic [IW-1:0] i_wr_idx,
    input  logic [W-1:0]  i_wr_data,
    input  logic          i_rd_bank,
    input  logic [IW-1:0] i_rd_idx,
    output logic [W-1:0]  o_rd_data
);

    logic [W-1:0] r_mem [2][N];

    // Sample write into the selected bank; storage carries no reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_bank][i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_bank][i_rd_idx];

endmodule

// File: rtl/ir_frame_sequencer.sv
// Frame sequencer for the FFT-based IR convolution path: collects samples into
// ping-pong frames, bursts each frame zero-padded into the FFT, and generates
// the IR-weight address and overlap-add strobes.
// Optional statistics counters: define IR_FRAME_SEQUENCER_STATS_EN.
module ir_frame_sequencer
    import ir_fx_pkg::*;
#(
    parameter int fxp_size    = 32,
    parameter int window_size = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    ir_frame_sequencer_if.slave   bus
);

    localparam int N  = window_size;
    localparam int N2 = fft_size(window_size);
    localparam int IW = $clog2(N);
    localparam int AW = $clog2(N2);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [AW-1:0] LAST_CNT = AW'(N2 - 1);

    seq_state_t          r_state;
    seq_state_t          w_state_next;
    logic                w_burst_entry;
    logic [AW-1:0]       w_cnt_next;

    logic                r_wr_bank;
    logic                r_rd_bank;
    logic                r_pending;
    logic                r_overrun;
    logic                r_fft_en;
    logic [IW-1:0]       r_wr_idx;
    logic [AW-1:0]       r_cnt;
    logic [AW-1:0]       r_ir_cnt;
    logic [AW-1:0]       r_ret_cnt;
    logic [fxp_size-1:0] r_fft_sample;

    logic                w_complete;
    logic                w_accept;
    logic                w_drop;
    logic                w_wr_en;
    logic                w_rd_bank_sel;
    logic [IW-1:0]       w_rd_idx;
    logic [fxp_size-1:0] w_rd_data;

    // A frame completes on its N-th sample; it is only taken when nothing is
    // queued and no burst is running, otherwise it is dropped.
    assign w_complete = bus.i_valid && (r_wr_idx == LAST_IDX);
    assign w_accept   = w_complete && !r_pending && (r_state == IDLE);
    assign w_drop     = w_complete && !w_accept;

    assign w_wr_en       = bus.i_valid && !rst;
    // On burst entry the bank just filled is the one wr_bank flipped away from.
    assign w_rd_bank_sel = w_burst_entry ? ~r_wr_bank : r_rd_bank;
    assign w_rd_idx      = w_cnt_next[IW-1:0];

    ir_frame_pingpong #(
        .W (fxp_size),
        .N (N)
    ) u_frames (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_bank (r_wr_bank),
        .i_wr_idx  (r_wr_idx),
        .i_wr_data (bus.i_sample),
        .i_rd_bank (w_rd_bank_sel),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and burst-position lookahead.
    always_comb begin
        w_state_next  = r_state;
        w_burst_entry = 1'b0;
        w_cnt_next    = r_cnt + 1'b1;
        case (r_state)
            IDLE: begin
                if (r_pending) begin
                    w_state_next  = BURST;
                    w_burst_entry = 1'b1;
                    w_cnt_next    = '0;
                end
            end
            BURST: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Frame fill, bank handoff and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_idx  <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (bus.i_valid) begin
                r_wr_idx <= w_complete ? '0 : r_wr_idx + 1'b1;
            end
            if (w_accept) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_burst_entry) begin
                r_pending <= 1'b0;
                r_rd_bank <= ~r_wr_bank;
            end else if (w_accept) begin
                r_pending <= 1'b1;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Registered FFT feed: first half from the frame, second half zero padding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_fft_en     <= 1'b0;
            r_fft_sample <= '0;
        end else begin
            r_cnt        <= (w_state_next == BURST) ? w_cnt_next : '0;
            r_fft_en     <= (w_state_next == BURST);
            r_fft_sample <= ((w_state_next == BURST) && !w_cnt_next[AW-1]) ? w_rd_data : '0;
        end
    end

    // Free-running bin counters for the weight ROM and the overlap-add return.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir_cnt  <= '0;
            r_ret_cnt <= '0;
        end else begin
            if (bus.i_fft_valid) begin
                r_ir_cnt <= r_ir_cnt + 1'b1;
            end
            if (bus.i_ifft_valid) begin
                r_ret_cnt <= r_ret_cnt + 1'b1;
            end
        end
    end

    assign bus.o_fft_en     = r_fft_en;
    assign bus.o_fft_sample = r_fft_sample;
    assign bus.o_ir_addr    = r_ir_cnt;
    assign bus.o_ola_acc    = bus.i_ifft_valid && !r_ret_cnt[AW-1];
    assign bus.o_ola_shift  = bus.i_ifft_valid && (r_ret_cnt == LAST_CNT);
    assign bus.o_frame_done = bus.i_ifft_valid && (r_ret_cnt == LAST_CNT);
    assign bus.o_busy       = (r_state == BURST);
    assign bus.o_overrun    = r_overrun;
    assign bus.o_dbg_state  = r_state;

`ifdef IR_FRAME_SEQUENCER_STATS_EN
    logic [15:0] r_frames_issued;
    logic [15:0] r_frames_dropped;

    // Saturating counts of issued bursts and dropped frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frames_issued  <= '0;
            r_frames_dropped <= '0;
        end else begin
            if (w_burst_entry && (r_frames_issued != 16'hFFFF)) begin
                r_frames_issued <= r_frames_issued + 16'd1;
            end
            if (w_drop && (r_frames_dropped != 16'hFFFF)) begin
                r_frames_dropped <= r_frames_dropped + 16'd1;
            end
        end
    end

    assign bus.o_frames_issued  = r_frames_issued;
    assign bus.o_frames_dropped = r_frames_dropped;
`endif

endmodule

// File: tb/tb_ir_frame_sequencer.sv
// Self-checking bench for ir_frame_sequencer with window_size = 8.
// Checks stats outputs too when IR_FRAME_SEQUENCER_STATS_EN is defined.
module tb_ir_frame_sequencer;
    import ir_fx_pkg::*;

    localparam int N  = 8;
    localparam int N2 = 2 * N;
    localparam int W  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   rand_side = 1'b0;

    ir_frame_sequencer_if #(.FXP_W(W), .N(N)) bus();

    ir_frame_sequencer #(
        .fxp_size    (W),
        .window_size (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock generation.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model state ----------------
    logic [W-1:0] fill_buf [N];
    logic [W-1:0] burst_data [N2];
    int fill_idx, last_accept, burst_start, n_edges;
    bit burst_on, m_overrun, model_live;
    int m_ir, m_ret, m_issued, m_dropped;

    // Monitor state used by the directed tests.
    logic [W-1:0] cap_q[$];
    int  bursts = 0;
    logic prev_en = 1'b0;
    int  last_valid_cyc = 0;
    int  first_en_cyc = 0;

    // Compare against the model every cycle, then advance the model with the
    // inputs that the coming rising edge will sample.
    initial begin : compare_proc
        int k, x, exp_iss;
        logic exp_en;
        logic [W-1:0] exp_s;
        n_edges    = 0;
        model_live = 1'b0;
        forever begin
            @(negedge clk);
            if (model_live) begin
                k      = n_edges - burst_start;
                exp_en = burst_on && (k >= 0) && (k < N2);
                exp_s  = '0;
                if (exp_en) exp_s = burst_data[k];
                check("fft_en", bus.o_fft_en, exp_en);
                check("fft_sample", bus.o_fft_sample, exp_s);
                check("busy", bus.o_busy, exp_en);
                check("overrun", bus.o_overrun, m_overrun);
                check("ola_acc", bus.o_ola_acc, bus.i_ifft_valid && (m_ret < N));
                check("ola_shift", bus.o_ola_shift, bus.i_ifft_valid && (m_ret == N2 - 1));
                check("frame_done", bus.o_frame_done, bus.i_ifft_valid && (m_ret == N2 - 1));
                if (bus.i_fft_valid) check("ir_addr", bus.o_ir_addr, m_ir);
`ifdef IR_FRAME_SEQUENCER_STATS_EN
                exp_iss = m_issued;
                if (burst_on && (burst_start > n_edges)) exp_iss = m_issued - 1;
                check("frames_issued", bus.o_frames_issued, exp_iss);
                check("frames_dropped", bus.o_frames_dropped, m_dropped);
`endif
            end
            // Monitor for directed checks.
            if (bus.o_fft_en === 1'b1) begin
                cap_q.push_back(bus.o_fft_sample);
                if (prev_en !== 1'b1) begin
                    bursts++;
                    first_en_cyc = n_edges;
                end
            end
            prev_en = bus.o_fft_en;
            if (bus.i_valid && !rst) last_valid_cyc = n_edges;

            // Advance the model.
            x = n_edges + 1;
            if (rst) begin
                fill_idx    = 0;
                burst_on    = 1'b0;
                m_overrun   = 1'b0;
                last_accept = -1000;
                burst_start = -1000;
                m_ir = 0; m_ret = 0; m_issued = 0; m_dropped = 0;
                model_live  = 1'b1;
            end else if (model_live) begin
                if (bus.i_valid) begin
                    fill_buf[fill_idx] = bus.i_sample;
                    if (fill_idx == N - 1) begin
                        fill_idx = 0;
                        // Accepted only once the previous burst has fully ended
                        // and the sequencer has settled back to idle.
                        if (x >= last_accept + N2 + 2) begin
                            last_accept = x;
                            burst_start = x + 1;
                            burst_on    = 1'b1;
                            if (m_issued < 65535) m_issued++;
                            for (int i = 0; i < N2; i++)
                                burst_data[i] = (i < N) ? fill_buf[i] : '0;
                        end else begin
                            m_overrun = 1'b1;
                            if (m_dropped < 65535) m_dropped++;
                        end
                    end else begin
                        fill_idx++;
                    end
                end
                if (bus.i_fft_valid)  m_ir  = (m_ir + 1) % N2;
                if (bus.i_ifft_valid) m_ret = (m_ret + 1) % N2;
            end
            n_edges++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_side) begin
            bus.i_fft_valid  = 1'($urandom_range(0, 1));
            bus.i_ifft_valid = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_sample(input logic [W-1:0] v, input int gap);
        bus.i_valid  = 1'b1;
        bus.i_sample = v;
        tick();
        bus.i_valid  = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_frame(input int base, input int gap);
        for (int i = 0; i < N; i++) send_sample(W'(base + i), gap);
    endtask

    task automatic wait_bursts(input int target, input string name);
        int guard;
        guard = 0;
        while (((bursts < target) || (bus.o_fft_en === 1'b1)) && (guard < 400)) begin
            tick();
            guard++;
        end
        check({name, "_timeout"}, guard < 400, 1'b1);
    endtask

    task automatic check_capture(input string name, input int base, input int off);
        for (int i = 0; i < N2; i++) begin
            if (off + i < cap_q.size())
                check(name, cap_q[off + i], (i < N) ? W'(base + i) : '0);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin : main_proc
        int b0, guard;
        bus.i_valid      = 1'b0;
        bus.i_sample     = '0;
        bus.i_fft_valid  = 1'b0;
        bus.i_ifft_valid = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        #3;
        check("rst_fft_en", bus.o_fft_en, 1'b0);
        check("rst_busy", bus.o_busy, 1'b0);
        check("rst_overrun", bus.o_overrun, 1'b0);
        check("rst_fft_sample", bus.o_fft_sample, '0);
        check("rst_ir_addr", bus.o_ir_addr, '0);

        // Single frame 1..8, one sample every 5 cycles.
        cap_q.delete();
        b0 = bursts;
        send_frame(1, 4);
        wait_bursts(b0 + 1, "t1");
        check("t1_len", cap_q.size(), N2);
        check_capture("t1_sample", 1, 0);
        check("t1_latency", first_en_cyc - last_valid_cyc, 2);

        // Weight address and overlap-add strobes.
        for (int i = 0; i <= N2; i++) begin
            bus.i_fft_valid = 1'b1;
            #3;
            check("t2_ir_addr", bus.o_ir_addr, i % N2);
            tick();
        end
        bus.i_fft_valid = 1'b0;
        for (int i = 0; i < N2; i++) begin
            bus.i_ifft_valid = 1'b1;
            #3;
            check("t2_ola_acc", bus.o_ola_acc, i < N);
            check("t2_ola_shift", bus.o_ola_shift, i == N2 - 1);
            check("t2_frame_done", bus.o_frame_done, i == N2 - 1);
            tick();
        end
        bus.i_ifft_valid = 1'b0;
        repeat (2) tick();

        // Overrun: second frame lands during the first burst.
        b0 = bursts;
        send_frame(100, 0);
        repeat (2) tick();
        send_frame(120, 0);
        wait_bursts(b0 + 1, "t3a");
        repeat (5) tick();
        check("t3_overrun_set", bus.o_overrun, 1'b1);
        check("t3_one_burst", bursts, b0 + 1);
        cap_q.delete();
        send_frame(140, 2);
        wait_bursts(b0 + 2, "t3b");
        check("t3_third_len", cap_q.size(), N2);
        check_capture("t3_third_sample", 140, 0);
        check("t3_overrun_sticky", bus.o_overrun, 1'b1);

        // Reset in the middle of a burst.
        b0 = bursts;
        send_frame(30, 1);
        guard = 0;
        while ((bursts == b0) && (guard < 100)) begin
            tick();
            guard++;
        end
        check("t4_start_timeout", guard < 100, 1'b1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #3;
        check("t4_fft_en_off", bus.o_fft_en, 1'b0);
        check("t4_overrun_clr", bus.o_overrun, 1'b0);
        tick();
        cap_q.delete();
        b0 = bursts;
        send_frame(50, 0);
        wait_bursts(b0 + 1, "t4");
        check("t4_len", cap_q.size(), N2);
        check_capture("t4_sample", 50, 0);

        // Back-to-back frames with 20-cycle sample spacing.
        cap_q.delete();
        b0 = bursts;
        send_frame(1, 19);
        send_frame(9, 19);
        wait_bursts(b0 + 2, "t5");
        check("t5_len", cap_q.size(), 2 * N2);
        check_capture("t5_first", 1, 0);
        check_capture("t5_second", 9, N2);
        check("t5_no_overrun", bus.o_overrun, 1'b0);

        // Randomized frames, gaps and FFT/IFFT strobes against the model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rand_side = 1'b1;
        for (int f = 0; f < 14; f++) begin
            for (int i = 0; i < N; i++) send_sample($urandom, $urandom_range(0, 3));
            repeat ($urandom_range(0, 20)) tick();
        end
        repeat (40) tick();
        rand_side = 1'b0;
        bus.i_fft_valid  = 1'b0;
        bus.i_ifft_valid = 1'b0;

`ifdef IR_FRAME_SEQUENCER_STATS_EN
        // Three issued frames and one dropped.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b0 = bursts;
        send_frame(200, 0);
        wait_bursts(b0 + 1, "t6a");
        send_frame(210, 0);
        wait_bursts(b0 + 2, "t6b");
        send_frame(220, 0);
        repeat (2) tick();
        send_frame(230, 0);
        wait_bursts(b0 + 3, "t6c");
        repeat (3) tick();
        check("t6_issued", bus.o_frames_issued, 16'd3);
        check("t6_dropped", bus.o_frames_dropped, 16'd1);
`endif

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time bound.
    initial begin : watchdog
        #500000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
